btn_conditioner: RTL

Multi-channel push-button front end: synchronizes raw board buttons to `clk`, debounces each channel independently, and emits a clean level plus one-cycle press/release pulses (optionally auto-repeat pulses). Sits between the board button pins and the control logic (counter/state machine), and is the input-side counterpart of the display driver.

---
 rtl/btn_pkg.sv | 25 ++
 rtl/btn_channel.sv | 138 +++++++++++++
 rtl/btn_conditioner.sv | 36 +++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared types, default timing and the counter-width helper for the button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    Idle,
    ArmPress,
    Held,
    ArmRelease
  } btn_state_t;

  localparam int unsigned DefN              = 5;
  localparam int unsigned DefDebounceCycles = 1_000_000;
  localparam int unsigned DefRepeatDelay    = 50_000_000;
  localparam int unsigned DefRepeatPeriod   = 10_000_000;

  // Width able to hold the largest of the three timing constants.
  function automatic int unsigned cnt_width(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchronizer, debounce FSM and optional auto-repeat.
// Auto-repeat logic is built only when BTN_AUTOREPEAT_EN is defined.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DebounceCycles = DefDebounceCycles,
  parameter int unsigned RepeatDelay    = DefRepeatDelay,
  parameter int unsigned RepeatPeriod   = DefRepeatPeriod
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic rpt_o
);

  localparam int unsigned CntW = cnt_width(DebounceCycles, RepeatDelay, RepeatPeriod);
  localparam logic [CntW-1:0] DebLast = CntW'(DebounceCycles - 1);

  logic [1:0]      sync_q;
  logic            sync;
  btn_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;

  assign sync = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      state_q   <= Idle;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      Idle: begin
        if (sync) begin
          state_d = ArmPress;
          cnt_d   = '0;
        end
      end
      ArmPress: begin
        if (!sync)                state_d = Idle;
        else if (cnt_q == DebLast) state_d = Held;
        else                      cnt_d   = cnt_q + 1'b1;
      end
      Held: begin
        if (!sync) begin
          state_d = ArmRelease;
          cnt_d   = '0;
        end
      end
      ArmRelease: begin
        if (sync)                  state_d = Held;
        else if (cnt_q == DebLast) state_d = Idle;
        else                       cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = Idle;
    endcase
  end

  always_comb begin
    level_d   = (state_d == Held) || (state_d == ArmRelease);
    press_d   = (state_q == ArmPress) && (state_d == Held);
    release_d = (state_q == ArmRelease) && (state_d == Idle);
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CntW-1:0] DelayLast  = CntW'(RepeatDelay - 1);
  localparam logic [CntW-1:0] PeriodLast = CntW'(RepeatPeriod - 1);

  logic [CntW-1:0] rcnt_q, rcnt_d;
  logic            first_q, first_d;
  logic            rpt_q, rpt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt_q  <= '0;
      first_q <= 1'b1;
      rpt_q   <= 1'b0;
    end else begin
      rcnt_q  <= rcnt_d;
      first_q <= first_d;
      rpt_q   <= rpt_d;
    end
  end

  // Counts only while HELD, so an aborted release freezes the repeat phase.
  always_comb begin
    rcnt_d  = rcnt_q;
    first_d = first_q;
    rpt_d   = 1'b0;
    if (press_d) begin
      rcnt_d  = '0;
      first_d = 1'b1;
    end else if (state_q == Held) begin
      if (rcnt_q == (first_q ? DelayLast : PeriodLast)) begin
        rpt_d   = 1'b1;
        rcnt_d  = '0;
        first_d = 1'b0;
      end else begin
        rcnt_d = rcnt_q + 1'b1;
      end
    end
    if (state_d == Idle && state_q != Idle) begin
      rcnt_d  = '0;
      first_d = 1'b1;
    end
  end

  assign rpt_o = rpt_q;
`else
  assign rpt_o = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// N-channel push-button front end: synchronize, debounce, press/release/repeat pulses.
// Auto-repeat is enabled by defining BTN_AUTOREPEAT_EN; `release` is a keyword, hence release_o.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned N               = DefN,
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
  parameter int unsigned REPEAT_PERIOD   = DefRepeatPeriod
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn_in,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] release_o,
  output logic [N-1:0] rpt
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    btn_channel #(
      .DebounceCycles(DEBOUNCE_CYCLES),
      .RepeatDelay   (REPEAT_DELAY),
      .RepeatPeriod  (REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .btn_i    (btn_in[i]),
      .level_o  (level[i]),
      .press_o  (press[i]),
      .release_o(release_o[i]),
      .rpt_o    (rpt[i])
    );
  end

endmodule
